// File: rtl/player_ctrl_pkg.sv
// Shared types and helpers for the multi-player movement controller.
package player_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE,
      MOVING,
      JUMPING,
      SLIDING
   } pc_state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/lerp_unit.sv
// Signed linear interpolation a + ((b - a) * cnt) / FRAMES, truncated toward zero.
module lerp_unit #(
   parameter int COORD_W = 10,
   parameter int CNT_W   = 5,
   parameter int FRAMES  = 24
) (
   input  logic [COORD_W-1:0] a,
   input  logic [COORD_W-1:0] b,
   input  logic [CNT_W-1:0]   cnt,
   output logic [COORD_W-1:0] value
);

   localparam int XW = 2*COORD_W + 1;

   logic signed [XW-1:0] diff;
   logic signed [XW-1:0] prod;
   logic signed [XW-1:0] quot;

   // Wide signed intermediates so backward moves divide toward zero.
   assign diff  = $signed(XW'(b)) - $signed(XW'(a));
   assign prod  = diff * $signed(XW'(cnt));
   assign quot  = prod / $signed(XW'(FRAMES));
   assign value = COORD_W'($signed(XW'(a)) + quot);

endmodule

// File: rtl/multi_player_controller.sv
// Turn-based sprite controller: move, jump and optional flag slide for one player per turn.
module multi_player_controller
   import player_ctrl_pkg::*;
#(
   parameter int NUM_PLAYERS  = 4,
   parameter int COORD_W      = 10,
   parameter int START_X      = 20,
   parameter int FLAG_X       = 620,
   parameter int BASE_Y       = 124,
   parameter int FLAG_TOP_Y   = 90,
   parameter int MOVE_FRAMES  = 24,
   parameter int JUMP_FRAMES  = 16,
   parameter int SLIDE_FRAMES = 20,
   parameter int JUMP_PEAK    = 30,
   localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           frame_tick,
   input  logic                           req_valid,
   output logic                           req_ready,
   input  logic [PW-1:0]                  req_player,
   input  logic [COORD_W-1:0]             req_x,
   output logic                           req_error,
   output logic [NUM_PLAYERS*COORD_W-1:0] player_x,
   output logic [NUM_PLAYERS*COORD_W-1:0] player_y,
   output logic [PW-1:0]                  active,
   output logic                           busy,
   output logic                           turn_done,
   output logic [NUM_PLAYERS-1:0]         flag_done
);

   localparam int MAX_FRAMES = max3(MOVE_FRAMES, JUMP_FRAMES, SLIDE_FRAMES);
   localparam int CNT_W      = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;
   localparam int HALF_J     = JUMP_FRAMES / 2;

   pc_state_t            state;
   logic [CNT_W-1:0]     cnt;
   logic [COORD_W-1:0]   start_x;
   logic [COORD_W-1:0]   target_x;
   logic [COORD_W-1:0]   stored_x [NUM_PLAYERS];
   logic [COORD_W-1:0]   req_target;
   logic [COORD_W-1:0]   move_x;
   logic [COORD_W-1:0]   slide_y;
   logic [COORD_W-1:0]   jump_y;
   logic [31:0]          req_idx;
   logic [31:0]          jump_d;
   logic                 req_drop;
   logic                 last_tick;

   always_comb begin
      req_target = req_x;
      if (32'(req_x) < 32'(START_X)) begin
         req_target = COORD_W'(START_X);
      end else if (32'(req_x) > 32'(FLAG_X)) begin
         req_target = COORD_W'(FLAG_X);
      end
   end

   // Widened index so the range check stays meaningful for non-power-of-two counts.
   assign req_idx  = 32'(req_player);
   assign req_drop = (req_idx >= 32'(NUM_PLAYERS)) || flag_done[req_player];

   assign jump_d = (32'(cnt) <= 32'(HALF_J)) ? 32'(cnt) : 32'(JUMP_FRAMES) - 32'(cnt);
   assign jump_y = COORD_W'(32'(BASE_Y) - (32'(JUMP_PEAK) * jump_d) / 32'(HALF_J));

   lerp_unit #(.COORD_W(COORD_W), .CNT_W(CNT_W), .FRAMES(MOVE_FRAMES)) u_move_lerp (
      .a     (start_x),
      .b     (target_x),
      .cnt   (cnt),
      .value (move_x)
   );

   lerp_unit #(.COORD_W(COORD_W), .CNT_W(CNT_W), .FRAMES(SLIDE_FRAMES)) u_slide_lerp (
      .a     (COORD_W'(FLAG_TOP_Y)),
      .b     (COORD_W'(BASE_Y)),
      .cnt   (cnt),
      .value (slide_y)
   );

   always_comb begin
      case (state)
         MOVING:  last_tick = (cnt == CNT_W'(MOVE_FRAMES - 1));
         JUMPING: last_tick = (cnt == CNT_W'(JUMP_FRAMES - 1));
         SLIDING: last_tick = (cnt == CNT_W'(SLIDE_FRAMES - 1));
         default: last_tick = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         active    <= '0;
         start_x   <= COORD_W'(START_X);
         target_x  <= COORD_W'(START_X);
         flag_done <= '0;
         turn_done <= 1'b0;
         req_error <= 1'b0;
         for (int i = 0; i < NUM_PLAYERS; i++) begin
            stored_x[i] <= COORD_W'(START_X);
         end
      end else begin
         turn_done <= 1'b0;
         req_error <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  active <= req_player;
                  cnt    <= '0;
                  if (req_drop) begin
                     req_error <= 1'b1;
                  end else begin
                     start_x  <= stored_x[req_player];
                     target_x <= req_target;
                     state    <= (req_target == stored_x[req_player]) ? JUMPING : MOVING;
                  end
               end
            end
            default: begin
               if (frame_tick) begin
                  if (!last_tick) begin
                     cnt <= cnt + 1'b1;
                  end else begin
                     cnt <= '0;
                     case (state)
                        MOVING: begin
                           stored_x[active] <= target_x;
                           state            <= JUMPING;
                        end
                        JUMPING: begin
                           if (target_x == COORD_W'(FLAG_X)) begin
                              state <= SLIDING;
                           end else begin
                              state     <= IDLE;
                              turn_done <= 1'b1;
                           end
                        end
                        default: begin
                           flag_done[active] <= 1'b1;
                           state             <= IDLE;
                           turn_done         <= 1'b1;
                        end
                     endcase
                  end
               end
            end
         endcase
      end
   end

   assign req_ready = (state == IDLE);
   assign busy      = !req_ready;

   // Only the animating player deviates from its stored position.
   for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_out
      logic live;
      assign live = (state != IDLE) && (active == PW'(gi));
      assign player_x[gi*COORD_W +: COORD_W] = !live ? stored_x[gi] :
                                               (state == MOVING) ? move_x : target_x;
      assign player_y[gi*COORD_W +: COORD_W] = !live ? COORD_W'(BASE_Y) :
                                               (state == MOVING)  ? COORD_W'(BASE_Y) :
                                               (state == JUMPING) ? jump_y : slide_y;
   end

endmodule

// File: tb/tb_multi_player_controller.sv
// Directed scenario bench for multi_player_controller, plus a 5-player instance for index range errors.
module tb_multi_player_controller;

   localparam int NP = 4;
   localparam int CW = 10;

   logic             clk        = 1'b0;
   logic             rst        = 1'b1;
   logic             frame_tick = 1'b0;
   logic             req_valid  = 1'b0;
   logic [1:0]       req_player = '0;
   logic [CW-1:0]    req_x      = '0;
   logic             req_ready;
   logic             req_error;
   logic [NP*CW-1:0] player_x;
   logic [NP*CW-1:0] player_y;
   logic [1:0]       active;
   logic             busy;
   logic             turn_done;
   logic [NP-1:0]    flag_done;

   logic             req_valid5  = 1'b0;
   logic [2:0]       req_player5 = '0;
   logic [CW-1:0]    req_x5      = '0;
   logic             req_ready5;
   logic             req_error5;
   logic [5*CW-1:0]  player_x5;
   logic [5*CW-1:0]  player_y5;
   logic [2:0]       active5;
   logic             busy5;
   logic             turn_done5;
   logic [4:0]       flag_done5;

   int n_cmp = 0;
   int n_err = 0;

   multi_player_controller u_dut (
      .clk        (clk),
      .rst        (rst),
      .frame_tick (frame_tick),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_player (req_player),
      .req_x      (req_x),
      .req_error  (req_error),
      .player_x   (player_x),
      .player_y   (player_y),
      .active     (active),
      .busy       (busy),
      .turn_done  (turn_done),
      .flag_done  (flag_done)
   );

   multi_player_controller #(.NUM_PLAYERS(5)) u_dut5 (
      .clk        (clk),
      .rst        (rst),
      .frame_tick (frame_tick),
      .req_valid  (req_valid5),
      .req_ready  (req_ready5),
      .req_player (req_player5),
      .req_x      (req_x5),
      .req_error  (req_error5),
      .player_x   (player_x5),
      .player_y   (player_y5),
      .active     (active5),
      .busy       (busy5),
      .turn_done  (turn_done5),
      .flag_done  (flag_done5)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic int px(input int i);
      return int'(player_x[i*CW +: CW]);
   endfunction

   function automatic int py(input int i);
      return int'(player_y[i*CW +: CW]);
   endfunction

   task automatic tick_edge();
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
   endtask

   task automatic tick();
      tick_edge();
      repeat (3) @(negedge clk);
   endtask

   task automatic run_ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic send_req(input int p, input int x);
      req_player = 2'(p);
      req_x      = CW'(x);
      req_valid  = 1'b1;
      @(negedge clk);
      req_valid  = 1'b0;
      $display("request player=%0d x=%0d busy=%0b req_error=%0b", p, x, busy, req_error);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < NP; i++) begin
         n_cmp++;
         if (px(i) !== 20) begin n_err++; $display("FAIL reset_x p%0d got %0d want 20", i, px(i)); end
         n_cmp++;
         if (py(i) !== 124) begin n_err++; $display("FAIL reset_y p%0d got %0d want 124", i, py(i)); end
      end
      n_cmp++;
      if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", req_ready); end
      n_cmp++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
      n_cmp++;
      if ({turn_done, req_error} !== 2'b00) begin n_err++; $display("FAIL reset_pulses got %b want 00", {turn_done, req_error}); end
      n_cmp++;
      if (flag_done !== 4'b0000) begin n_err++; $display("FAIL reset_flag_done got %b want 0000", flag_done); end
      n_cmp++;
      if (active !== 2'd0) begin n_err++; $display("FAIL reset_active got %0d want 0", active); end
      n_cmp++;
      if (req_ready5 !== 1'b1) begin n_err++; $display("FAIL reset_ready5 got %b want 1", req_ready5); end
      $display("reset released");
   endtask

   task automatic test_move_p0();
      int want;
      int d;
      send_req(0, 100);
      n_cmp++;
      if (busy !== 1'b1 || req_ready !== 1'b0) begin n_err++; $display("FAIL accept_busy got busy=%b ready=%b want 1/0", busy, req_ready); end
      n_cmp++;
      if (px(0) !== 20) begin n_err++; $display("FAIL move_first_x got %0d want 20", px(0)); end
      for (int k = 1; k < 24; k++) begin
         tick();
         want = 20 + (80 * k) / 24;
         n_cmp++;
         if (px(0) !== want || py(0) !== 124) begin
            n_err++; $display("FAIL move_x k=%0d got (%0d,%0d) want (%0d,124)", k, px(0), py(0), want);
         end
      end
      tick();
      n_cmp++;
      if (px(0) !== 100 || py(0) !== 124) begin n_err++; $display("FAIL jump_start got (%0d,%0d) want (100,124)", px(0), py(0)); end
      for (int k = 1; k < 16; k++) begin
         tick();
         d = (k <= 8) ? k : 16 - k;
         want = 124 - (30 * d) / 8;
         n_cmp++;
         if (py(0) !== want || turn_done !== 1'b0) begin
            n_err++; $display("FAIL jump_y k=%0d got %0d td=%b want %0d td=0", k, py(0), turn_done, want);
         end
         if (k == 8) begin
            n_cmp++;
            if (py(0) !== 94) begin n_err++; $display("FAIL jump_apex got %0d want 94", py(0)); end
         end
      end
      tick_edge();
      n_cmp++;
      if (turn_done !== 1'b1 || req_ready !== 1'b1) begin n_err++; $display("FAIL p0_turn_done got td=%b ready=%b want 1/1", turn_done, req_ready); end
      n_cmp++;
      if (px(0) !== 100 || py(0) !== 124) begin n_err++; $display("FAIL p0_final got (%0d,%0d) want (100,124)", px(0), py(0)); end
      @(negedge clk);
      n_cmp++;
      if (turn_done !== 1'b0) begin n_err++; $display("FAIL p0_td_pulse got %b want 0", turn_done); end
      repeat (2) @(negedge clk);
      $display("turn player=0 done x=%0d", px(0));
   endtask

   task automatic test_backward();
      int want;
      int prev;
      logic [3*CW-1:0] others;
      logic [3*CW-1:0] others_y;
      send_req(2, 300);
      run_ticks(40);
      n_cmp++;
      if (px(2) !== 300) begin n_err++; $display("FAIL p2_setup got %0d want 300", px(2)); end
      send_req(2, 200);
      prev = 300;
      for (int k = 1; k <= 24; k++) begin
         tick();
         want = (k < 24) ? 300 + (-100 * k) / 24 : 200;
         n_cmp++;
         if (px(2) !== want || px(2) >= prev) begin
            n_err++; $display("FAIL back_x k=%0d got %0d want %0d below %0d", k, px(2), want, prev);
         end
         prev = px(2);
         others   = {player_x[4*CW-1:3*CW], player_x[2*CW-1:0]};
         others_y = {player_y[4*CW-1:3*CW], player_y[2*CW-1:0]};
         n_cmp++;
         if (others !== {10'd20, 10'd20, 10'd100} || others_y !== {3{10'd124}}) begin
            n_err++; $display("FAIL back_others k=%0d got %h/%h want %h/%h", k, others, others_y, {10'd20, 10'd20, 10'd100}, {3{10'd124}});
         end
      end
      run_ticks(16);
      n_cmp++;
      if (px(2) !== 200 || busy !== 1'b0) begin n_err++; $display("FAIL back_final got x=%0d busy=%b want 200/0", px(2), busy); end
      $display("turn player=2 done x=%0d", px(2));
   endtask

   task automatic test_flag();
      int want;
      send_req(1, 700);
      n_cmp++;
      if (active !== 2'd1) begin n_err++; $display("FAIL flag_active got %0d want 1", active); end
      for (int k = 1; k <= 24; k++) begin
         tick();
         want = (k < 24) ? 20 + (600 * k) / 24 : 620;
         n_cmp++;
         if (px(1) !== want) begin n_err++; $display("FAIL flag_move k=%0d got %0d want %0d", k, px(1), want); end
      end
      run_ticks(16);
      n_cmp++;
      if (py(1) !== 90 || busy !== 1'b1) begin n_err++; $display("FAIL slide_start got y=%0d busy=%b want 90/1", py(1), busy); end
      for (int k = 1; k < 20; k++) begin
         tick();
         want = 90 + (34 * k) / 20;
         n_cmp++;
         if (py(1) !== want || px(1) !== 620) begin
            n_err++; $display("FAIL slide_y k=%0d got (%0d,%0d) want (620,%0d)", k, px(1), py(1), want);
         end
      end
      tick_edge();
      n_cmp++;
      if (turn_done !== 1'b1 || flag_done !== 4'b0010 || py(1) !== 124) begin
         n_err++; $display("FAIL slide_end got td=%b flags=%b y=%0d want 1/0010/124", turn_done, flag_done, py(1));
      end
      repeat (3) @(negedge clk);
      send_req(1, 100);
      n_cmp++;
      if (req_error !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL flag_drop got err=%b busy=%b want 1/0", req_error, busy); end
      @(negedge clk);
      n_cmp++;
      if (req_error !== 1'b0) begin n_err++; $display("FAIL flag_drop_pulse got %b want 0", req_error); end
      tick();
      n_cmp++;
      if (px(1) !== 620 || busy !== 1'b0) begin n_err++; $display("FAIL flag_no_motion got x=%0d busy=%b want 620/0", px(1), busy); end
      $display("turn player=1 flag reached, later request dropped");
   endtask

   task automatic test_zero();
      send_req(0, 100);
      n_cmp++;
      if (busy !== 1'b1 || px(0) !== 100 || py(0) !== 124) begin
         n_err++; $display("FAIL zero_accept got busy=%b (%0d,%0d) want 1 (100,124)", busy, px(0), py(0));
      end
      tick();
      n_cmp++;
      if (py(0) !== 121 || px(0) !== 100) begin n_err++; $display("FAIL zero_jump1 got (%0d,%0d) want (100,121)", px(0), py(0)); end
      run_ticks(14);
      n_cmp++;
      if (turn_done !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL zero_early got td=%b busy=%b want 0/1", turn_done, busy); end
      tick_edge();
      n_cmp++;
      if (turn_done !== 1'b1) begin n_err++; $display("FAIL zero_done got %b want 1", turn_done); end
      repeat (3) @(negedge clk);
      $display("turn player=0 zero-distance done x=%0d", px(0));
   endtask

   task automatic test_back_to_back();
      req_player = 2'd3;
      req_x      = CW'(50);
      req_valid  = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b1) begin n_err++; $display("FAIL hold_accept got %b want 1", busy); end
      req_x = CW'(400);
      run_ticks(24);
      n_cmp++;
      if (px(3) !== 50) begin n_err++; $display("FAIL hold_ignored got %0d want 50", px(3)); end
      run_ticks(15);
      tick_edge();
      n_cmp++;
      if (turn_done !== 1'b1 || req_ready !== 1'b1) begin n_err++; $display("FAIL hold_done got td=%b ready=%b want 1/1", turn_done, req_ready); end
      @(negedge clk);
      req_valid = 1'b0;
      n_cmp++;
      if (busy !== 1'b1 || px(3) !== 50) begin n_err++; $display("FAIL hold_reaccept got busy=%b x=%0d want 1/50", busy, px(3)); end
      run_ticks(40);
      n_cmp++;
      if (px(3) !== 400 || busy !== 1'b0) begin n_err++; $display("FAIL hold_final got x=%0d busy=%b want 400/0", px(3), busy); end
      $display("turn player=3 back-to-back done x=%0d", px(3));
   endtask

   task automatic test_reset_mid();
      send_req(0, 200);
      run_ticks(28);
      n_cmp++;
      if (py(0) !== 109 || px(0) !== 200) begin n_err++; $display("FAIL mid_jump got (%0d,%0d) want (200,109)", px(0), py(0)); end
      #1;
      rst = 1'b1;
      #1;
      for (int i = 0; i < NP; i++) begin
         n_cmp++;
         if (px(i) !== 20 || py(i) !== 124) begin n_err++; $display("FAIL async_reset p%0d got (%0d,%0d) want (20,124)", i, px(i), py(i)); end
      end
      n_cmp++;
      if ({req_ready, busy, turn_done, req_error} !== 4'b1000 || flag_done !== 4'b0000 || active !== 2'd0) begin
         n_err++; $display("FAIL async_reset_ctl got %b flags=%b active=%0d want 1000/0000/0", {req_ready, busy, turn_done, req_error}, flag_done, active);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      $display("async reset during jump");
   endtask

   task automatic test_bad_index();
      req_player5 = 3'd5;
      req_x5      = CW'(100);
      req_valid5  = 1'b1;
      @(negedge clk);
      req_valid5  = 1'b0;
      $display("request (5-player dut) player=5 x=100 req_error=%0b", req_error5);
      n_cmp++;
      if (req_error5 !== 1'b1 || busy5 !== 1'b0) begin n_err++; $display("FAIL bad_index got err=%b busy=%b want 1/0", req_error5, busy5); end
      n_cmp++;
      if (player_x5 !== {5{10'd20}} || flag_done5 !== 5'b0) begin n_err++; $display("FAIL bad_index_state got %h flags=%b", player_x5, flag_done5); end
      @(negedge clk);
      n_cmp++;
      if (req_error5 !== 1'b0) begin n_err++; $display("FAIL bad_index_pulse got %b want 0", req_error5); end
   endtask

   initial begin
      test_reset();
      test_move_p0();
      test_backward();
      test_flag();
      test_zero();
      test_back_to_back();
      test_reset_mid();
      test_bad_index();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
